serial_frame_tx: RTL
====================

// Module: serial_frame_tx
// PURPOSE
//  Multi-channel framed serial sender to the STM32 on one data line (sda), single clock domain.
//  Generalises the single-word sender: channel ID header, optional even parity, input FIFO with valid/ready, any integer bit period.
//  Sits between the measurement/demod cores (producers) and the MCU capture pin.
// PARAMETERS
//  CLK_DIV    500  clk cycles per bit period; any integer >= 2 (odd allowed)
//  DATA_W     32   payload width, 1..64
//  NUM_CH     4    number of logical channels; CH_W = (NUM_CH>1) ? $clog2(NUM_CH) : 1
//  FIFO_DEPTH 4    input FIFO entries, power of 2, >= 2
//  PARITY_EN  1    1: append even-parity bit over {ch,data}; 0: no parity bit
//  GAP_BITS   1    low bit periods forced after each frame, >= 1
// PORTS
//  clk         in   1                     system clock
//  rst_n       in   1                     async reset, active low
//  en          in   1                     1: may start new frames; 0: finish current frame, then hold
//  in_valid    in   1                     producer has word
//  in_ready    out  1                     FIFO can accept (= !full)
//  in_ch       in   CH_W                  channel ID of word
//  in_data     in   DATA_W                payload
//  sda         out  1                     serial line to MCU, idle low, registered
//  busy        out  1                     1 from frame start until end of gap
//  frame_done  out  1                     1-cycle pulse at end of gap
//  fifo_level  out  $clog2(FIFO_DEPTH+1)  entries stored
//  led         out  1                     toggles at each frame start
// BEHAVIOUR
//  Reset (async): sda=0, busy=0, frame_done=0, led=0, fifo_level=0, in_ready=1, FIFO emptied, FSM->IDLE.
//  Push on posedge when in_valid&&in_ready. When full, in_ready=0 even if a pop occurs that cycle.
//  in_ch values >= NUM_CH are accepted and sent verbatim.
//  Frame, MSB first: start(1) | ch[CH_W-1:0] | data[DATA_W-1:0] | parity (if PARITY_EN) | GAP_BITS x 0.
//  FRAME_BITS = 1+CH_W+DATA_W+PARITY_EN; parity = ^{ch,data}, so total ones in ch+data+parity is even.
//  FSM IDLE: when en && fifo_level!=0, pop head, load shift reg, sda<=1, busy<=1, led toggles -> SHIFT.
//  FSM SHIFT: each bit held exactly CLK_DIV cycles; after the last bit, sda<=0 -> GAP.
//  FSM GAP: sda=0 for GAP_BITS*CLK_DIV cycles; on the final cycle frame_done=1, busy<=0 -> IDLE.
//  Latency: word pushed at edge k into empty FIFO with FSM idle -> sda=1 after edge k+1.
//  Back-to-back frames: next start bit follows the gap directly; no extra idle cycle beyond the IDLE decision cycle.
//  Frame period = (FRAME_BITS+GAP_BITS)*CLK_DIV+1 cycles.
//  Bit-period counter is free of the FSM's derived clocks; all logic is on clk (no generated clock).
//  en falling mid-frame: frame and gap complete normally; no new pop while en=0.
//  Simultaneous push and pop with non-full FIFO: both occur, fifo_level unchanged.
//  Pointers wrap modulo FIFO_DEPTH; order strictly FIFO.
//  Reset mid-frame: sda drops to 0 immediately; queued words are lost.
// TESTING
//  Config CLK_DIV=4, DATA_W=8, NUM_CH=4, FIFO_DEPTH=4, PARITY_EN=1, GAP_BITS=1 unless stated.
//  1 Single word: push ch=2, data=0xA5 -> sda bits 1,1,0,1,0,1,0,0,1,0,1,1 each 4 cycles, then 4 cycles low; frame_done once; led=1.
//  2 Fill: en=0, assert in_valid 6 cycles -> 4 accepted, in_ready=0, fifo_level=4; en=1 -> 4 frames in order, each 12 bits + gap, period 53 cycles.
//  3 Parity: ch=0, data=0x01 -> parity bit 1; ch=3, data=0x00 -> parity 0; PARITY_EN=0 -> 11-bit frames.
//  4 en dropped mid data -> current frame and gap complete, no further start bit; en=1 resumes with next queued word.
//  5 rst_n low mid-frame -> sda=0 same cycle (async), fifo_level=0, in_ready=1; after release, line stays low until a new push.
//  6 CLK_DIV=5, push while a frame is in flight -> every bit is exactly 5 cycles; push/pop same cycle keeps fifo_level constant.

Source files
------------

// File: rtl/serial_frame_tx.sv
// Framed serial sender to the MCU: input FIFO feeding a start|ch|data|parity shifter,
// one bit every CLK_DIV clocks, followed by a forced-low gap.
module serial_frame_tx #(
  parameter int CLK_DIV    = 500,
  parameter int DATA_W     = 32,
  parameter int NUM_CH     = 4,
  parameter int FIFO_DEPTH = 4,
  parameter int PARITY_EN  = 1,
  parameter int GAP_BITS   = 1,
  localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
  localparam int LVL_W = $clog2(FIFO_DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CH_W-1:0]   in_ch,
  input  logic [DATA_W-1:0] in_data,
  output logic              sda,
  output logic              busy,
  output logic              frame_done,
  output logic [LVL_W-1:0]  fifo_level,
  output logic              led
);

  // state   | meaning
  // IDLE    | line low, waiting for en and a queued word
  // SHIFT   | start/ch/data/parity bits on sda, CLK_DIV cycles each
  // GAP     | line forced low for GAP_BITS bit periods
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_GAP   = 2'd2;

  localparam int ENT_W      = CH_W + DATA_W;
  localparam int PAY_W      = ENT_W + PARITY_EN;
  localparam int FRAME_BITS = 1 + PAY_W;
  localparam int PTR_W      = $clog2(FIFO_DEPTH);
  localparam int CNT_W      = $clog2(GAP_BITS * CLK_DIV);
  localparam int BIT_W      = $clog2(FRAME_BITS);

  localparam logic [CNT_W-1:0] BIT_RELOAD = CNT_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] GAP_RELOAD = CNT_W'(GAP_BITS * CLK_DIV - 1);
  localparam logic [BIT_W-1:0] BIT_LAST   = BIT_W'(FRAME_BITS - 1);
  localparam logic [LVL_W-1:0] LVL_FULL   = LVL_W'(FIFO_DEPTH);

  logic [ENT_W-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [LVL_W-1:0] level;
  logic [ENT_W-1:0] head;
  logic [PAY_W-1:0] payload;
  logic             push, pop;

  logic [1:0]       state;
  logic [PAY_W-1:0] shreg;
  logic [CNT_W-1:0] cnt;
  logic [BIT_W-1:0] bits_left;

  assign in_ready   = (level != LVL_FULL);
  assign push       = in_valid && in_ready;
  assign pop        = (state == ST_IDLE) && en && (level != '0);
  assign head       = mem[rd_ptr];
  assign fifo_level = level;
  assign busy       = (state != ST_IDLE);
  assign frame_done = (state == ST_GAP) && (cnt == '0);

  // Even parity: total ones across ch, data and the parity bit is even.
  generate
    if (PARITY_EN != 0) begin : g_par
      assign payload = {head, ^head};
    end else begin : g_nopar
      assign payload = head;
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {in_ch, in_data};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

  // cnt is a down-counter; a bit (or the whole gap) ends when it reaches zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      sda       <= 1'b0;
      led       <= 1'b0;
      shreg     <= '0;
      cnt       <= '0;
      bits_left <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (pop) begin
            shreg     <= payload;
            sda       <= 1'b1;
            led       <= ~led;
            cnt       <= BIT_RELOAD;
            bits_left <= BIT_LAST;
            state     <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          if (cnt == '0) begin
            if (bits_left == '0) begin
              sda   <= 1'b0;
              cnt   <= GAP_RELOAD;
              state <= ST_GAP;
            end else begin
              sda       <= shreg[PAY_W-1];
              shreg     <= shreg << 1;
              bits_left <= bits_left - 1'b1;
              cnt       <= BIT_RELOAD;
            end
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        ST_GAP: begin
          if (cnt == '0) state <= ST_IDLE;
          else           cnt   <= cnt - 1'b1;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
